// File: rtl/sprite_pkg.sv
// -----------------------------------------------------------------------------
// sprite_pkg
// Shared definitions for the sprite attribute fetcher:
//   - sprite table size (128 sprites, two 32-bit words each)
//   - bit positions of every attribute field in word0 / word1
//   - scan FSM state encoding
//   - size_decode(): 2-bit size code -> pixel extent (8 << code)
// -----------------------------------------------------------------------------
package sprite_pkg;

  localparam int SPRITE_COUNT = 128;

  // word0 layout
  localparam int W0_ADDR_LSB  = 0;
  localparam int W0_ADDR_MSB  = 11;
  localparam int W0_MODE_BIT  = 15;
  localparam int W0_X_LSB     = 16;
  localparam int W0_X_MSB     = 25;

  // word1 layout
  localparam int W1_Y_LSB     = 0;
  localparam int W1_Y_MSB     = 9;
  localparam int W1_HFLIP_BIT = 16;
  localparam int W1_VFLIP_BIT = 17;
  localparam int W1_Z_LSB     = 18;
  localparam int W1_Z_MSB     = 19;
  localparam int W1_COLL_LSB  = 20;
  localparam int W1_COLL_MSB  = 23;
  localparam int W1_PAL_LSB   = 24;
  localparam int W1_PAL_MSB   = 27;
  localparam int W1_WCODE_LSB = 28;
  localparam int W1_WCODE_MSB = 29;
  localparam int W1_HCODE_LSB = 30;
  localparam int W1_HCODE_MSB = 31;

  // Scan FSM encoding
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD0  = 3'd1;
  localparam logic [2:0] ST_RD1  = 3'd2;
  localparam logic [2:0] ST_EVAL = 3'd3;
  localparam logic [2:0] ST_OUT  = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  // Pixel extent for a size code: 8, 16, 32 or 64 (fits in 7 bits).
  function automatic logic [6:0] size_decode(input logic [1:0] code);
    return 7'd8 << code;
  endfunction

endpackage

// File: rtl/sprite_line_hit.sv
// -----------------------------------------------------------------------------
// sprite_line_hit
// Purely combinational test of one sprite against one scan line.
// Ports:
//   i_line   [9:0]  current scan line
//   i_y      [9:0]  sprite top line
//   i_hcode  [1:0]  height code (height = 8 << code)
//   i_vflip         vertical flip
//   i_z      [1:0]  priority; zero means sprite disabled
//   o_hit           sprite covers this line
//   o_row    [5:0]  source row inside the sprite (meaningful only on hit)
// -----------------------------------------------------------------------------
module sprite_line_hit
  import sprite_pkg::*;
(
  input  logic [9:0] i_line,
  input  logic [9:0] i_y,
  input  logic [1:0] i_hcode,
  input  logic       i_vflip,
  input  logic [1:0] i_z,
  output logic       o_hit,
  output logic [5:0] o_row
);

  logic [9:0] w_diff;
  logic [6:0] w_height;
  logic [6:0] w_flip_row;

  // 10-bit subtraction wraps, so sprites straddling line 1023 -> 0 still hit.
  assign w_diff   = i_line - i_y;
  assign w_height = size_decode(i_hcode);
  assign o_hit    = (i_z != 2'd0) && (w_diff < {3'b000, w_height});

  // On a hit diff < height <= 64, so the low 7 bits carry the whole value.
  assign w_flip_row = w_height - 7'd1 - w_diff[6:0];
  assign o_row      = i_vflip ? w_flip_row[5:0] : w_diff[5:0];

endmodule

// File: rtl/sprite_attr_fetch.sv
// -----------------------------------------------------------------------------
// sprite_attr_fetch
// Walks the 128-entry sprite attribute table for one scan line and emits every
// sprite that covers the line on a valid/ready stream, up to MAX_PER_LINE.
// Each sprite costs RD0 (read word0), RD1 (capture word0, read word1) and
// EVAL (capture word1, test); hits then wait in OUT for the consumer.
// Ports:
//   clk_i, rst_n_i            clock, async active-low reset
//   line_start_i, line_idx_i  start a scan of line line_idx_i (any state)
//   rd_en_o, rd_addr_o        attribute RAM read (data returns next cycle)
//   rd_data_i                 attribute RAM data
//   out_valid_o, out_ready_i  handshake for one visible sprite
//   idx_o .. wcode_o          sprite payload
//   busy_o, done_o            scan in progress / one-cycle end-of-scan pulse
//   overflow_o                only with SPRITE_FETCH_OVERFLOW_EN: scan was cut
//                             short by MAX_PER_LINE
// Build option: define SPRITE_FETCH_OVERFLOW_EN to add overflow_o.
// -----------------------------------------------------------------------------
module sprite_attr_fetch
  import sprite_pkg::*;
#(
  parameter int MAX_PER_LINE = 64
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        line_start_i,
  input  logic [9:0]  line_idx_i,
  output logic        rd_en_o,
  output logic [7:0]  rd_addr_o,
  input  logic [31:0] rd_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [6:0]  idx_o,
  output logic [11:0] addr_o,
  output logic        mode_o,
  output logic [9:0]  x_o,
  output logic [5:0]  row_o,
  output logic        hflip_o,
  output logic [1:0]  z_o,
  output logic [3:0]  coll_o,
  output logic [3:0]  pal_o,
  output logic [1:0]  wcode_o,
  output logic        busy_o,
`ifdef SPRITE_FETCH_OVERFLOW_EN
  output logic        overflow_o,
`endif
  output logic        done_o
);

  localparam logic [7:0] MAX_HITS = 8'(MAX_PER_LINE);
  localparam logic [6:0] LAST_SPRITE = 7'(SPRITE_COUNT - 1);

  logic [2:0]  r_state;
  logic [6:0]  r_sprite;
  logic [7:0]  r_hits;
  logic [9:0]  r_line;
  logic [11:0] r_w0_addr;
  logic        r_w0_mode;
  logic [9:0]  r_w0_x;

  logic [6:0]  r_idx;
  logic [11:0] r_addr;
  logic        r_mode;
  logic [9:0]  r_x;
  logic [5:0]  r_row;
  logic        r_hflip;
  logic [1:0]  r_z;
  logic [3:0]  r_coll;
  logic [3:0]  r_pal;
  logic [1:0]  r_wcode;

  logic        w_hit;
  logic [5:0]  w_row;
  logic        w_last;
  logic [7:0]  w_hits_inc;
  logic        w_xfer;
  logic        w_unused;

  assign w_last     = (r_sprite == LAST_SPRITE);
  assign w_hits_inc = r_hits + 8'd1;
  assign w_xfer     = (r_state == ST_OUT) && out_ready_i;
  assign w_unused   = ^{rd_data_i[14:12], rd_data_i[31:26]};

  // rd_data_i holds word1 while in EVAL; word0 fields were captured in RD1.
  sprite_line_hit u_line_hit (
    .i_line  (r_line),
    .i_y     (rd_data_i[W1_Y_MSB:W1_Y_LSB]),
    .i_hcode (rd_data_i[W1_HCODE_MSB:W1_HCODE_LSB]),
    .i_vflip (rd_data_i[W1_VFLIP_BIT]),
    .i_z     (rd_data_i[W1_Z_MSB:W1_Z_LSB]),
    .o_hit   (w_hit),
    .o_row   (w_row)
  );

  // NOTE: state registers use non-blocking assignments so every register in
  // this block samples the pre-edge values of the others, matching hardware.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= ST_IDLE;
      r_sprite  <= '0;
      r_hits    <= '0;
      r_line    <= '0;
      r_w0_addr <= '0;
      r_w0_mode <= 1'b0;
      r_w0_x    <= '0;
      r_idx     <= '0;
      r_addr    <= '0;
      r_mode    <= 1'b0;
      r_x       <= '0;
      r_row     <= '0;
      r_hflip   <= 1'b0;
      r_z       <= '0;
      r_coll    <= '0;
      r_pal     <= '0;
      r_wcode   <= '0;
    end else if (line_start_i) begin
      // A new line always wins, including over a pending OUT transfer.
      r_state  <= ST_RD0;
      r_sprite <= '0;
      r_hits   <= '0;
      r_line   <= line_idx_i;
    end else begin
      case (r_state)
        ST_RD0: r_state <= ST_RD1;
        ST_RD1: begin
          r_w0_addr <= rd_data_i[W0_ADDR_MSB:W0_ADDR_LSB];
          r_w0_mode <= rd_data_i[W0_MODE_BIT];
          r_w0_x    <= rd_data_i[W0_X_MSB:W0_X_LSB];
          r_state   <= ST_EVAL;
        end
        ST_EVAL: begin
          if (w_hit) begin
            r_idx   <= r_sprite;
            r_addr  <= r_w0_addr;
            r_mode  <= r_w0_mode;
            r_x     <= r_w0_x;
            r_row   <= w_row;
            r_hflip <= rd_data_i[W1_HFLIP_BIT];
            r_z     <= rd_data_i[W1_Z_MSB:W1_Z_LSB];
            r_coll  <= rd_data_i[W1_COLL_MSB:W1_COLL_LSB];
            r_pal   <= rd_data_i[W1_PAL_MSB:W1_PAL_LSB];
            r_wcode <= rd_data_i[W1_WCODE_MSB:W1_WCODE_LSB];
            r_state <= ST_OUT;
          end else if (w_last) begin
            r_state <= ST_DONE;
          end else begin
            r_sprite <= r_sprite + 7'd1;
            r_state  <= ST_RD0;
          end
        end
        ST_OUT: begin
          if (out_ready_i) begin
            r_hits <= w_hits_inc;
            if (w_hits_inc == MAX_HITS || w_last) begin
              r_state <= ST_DONE;
            end else begin
              r_sprite <= r_sprite + 7'd1;
              r_state  <= ST_RD0;
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef SPRITE_FETCH_OVERFLOW_EN
  logic r_overflow;

  // Only a cut that leaves sprites unscanned counts; filling up on sprite 127
  // lost nothing.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_overflow <= 1'b0;
    end else if (line_start_i) begin
      r_overflow <= 1'b0;
    end else if (w_xfer && (w_hits_inc == MAX_HITS) && !w_last) begin
      r_overflow <= 1'b1;
    end
  end

  assign overflow_o = r_overflow;
`endif

  // Read strobe and address follow the state directly: word 2n in RD0,
  // word 2n+1 in RD1.
  assign rd_en_o     = (r_state == ST_RD0) || (r_state == ST_RD1);
  assign rd_addr_o   = {r_sprite, (r_state == ST_RD1)};
  assign out_valid_o = (r_state == ST_OUT);
  assign busy_o      = (r_state == ST_RD0) || (r_state == ST_RD1) ||
                       (r_state == ST_EVAL) || (r_state == ST_OUT);
  assign done_o      = (r_state == ST_DONE);

  assign idx_o   = r_idx;
  assign addr_o  = r_addr;
  assign mode_o  = r_mode;
  assign x_o     = r_x;
  assign row_o   = r_row;
  assign hflip_o = r_hflip;
  assign z_o     = r_z;
  assign coll_o  = r_coll;
  assign pal_o   = r_pal;
  assign wcode_o = r_wcode;

endmodule

// File: tb/tb_sprite_attr_fetch.sv
// -----------------------------------------------------------------------------
// tb_sprite_attr_fetch
// Self-checking bench for sprite_attr_fetch. A behavioural RAM answers reads
// one cycle later (garbage when not reading); a reference model walks the
// sprite table with plain integer arithmetic to build the expected output
// list for a line. Define SPRITE_FETCH_OVERFLOW_EN to also check overflow_o.
// -----------------------------------------------------------------------------
module tb_sprite_attr_fetch;

  localparam int MAXL = 64;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        line_start_i;
  logic [9:0]  line_idx_i;
  logic        rd_en_o;
  logic [7:0]  rd_addr_o;
  logic [31:0] rd_data_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [6:0]  idx_o;
  logic [11:0] addr_o;
  logic        mode_o;
  logic [9:0]  x_o;
  logic [5:0]  row_o;
  logic        hflip_o;
  logic [1:0]  z_o;
  logic [3:0]  coll_o;
  logic [3:0]  pal_o;
  logic [1:0]  wcode_o;
  logic        busy_o;
  logic        done_o;
`ifdef SPRITE_FETCH_OVERFLOW_EN
  logic        overflow_o;
`endif

  sprite_attr_fetch #(.MAX_PER_LINE(MAXL)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .line_start_i (line_start_i),
    .line_idx_i   (line_idx_i),
    .rd_en_o      (rd_en_o),
    .rd_addr_o    (rd_addr_o),
    .rd_data_i    (rd_data_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .idx_o        (idx_o),
    .addr_o       (addr_o),
    .mode_o       (mode_o),
    .x_o          (x_o),
    .row_o        (row_o),
    .hflip_o      (hflip_o),
    .z_o          (z_o),
    .coll_o       (coll_o),
    .pal_o        (pal_o),
    .wcode_o      (wcode_o),
    .busy_o       (busy_o),
`ifdef SPRITE_FETCH_OVERFLOW_EN
    .overflow_o   (overflow_o),
`endif
    .done_o       (done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [6:0]  idx;
    logic [11:0] addr;
    logic        mode;
    logic [9:0]  x;
    logic [5:0]  row;
    logic        hflip;
    logic [1:0]  z;
    logic [3:0]  coll;
    logic [3:0]  pal;
    logic [1:0]  wcode;
  } pay_t;

  pay_t dut_pay;
  assign dut_pay = {idx_o, addr_o, mode_o, x_o, row_o, hflip_o, z_o, coll_o,
                    pal_o, wcode_o};

  logic [31:0] mem [256];
  int   errors = 0;
  int   checks = 0;
  pay_t exp_q[$];
  logic exp_ovf;
  pay_t last_xfer;
  int   n_xfer;
  int   done_cyc;

  // Attribute RAM: one-cycle read latency, random data when not reading.
  always @(posedge clk_i) begin
    if (rd_en_o) rd_data_i <= mem[rd_addr_o];
    else         rd_data_i <= $urandom();
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  endtask

  task automatic set_sprite(input int n, input int addr, input int mode,
                            input int x, input int y, input int hflip,
                            input int vflip, input int z, input int coll,
                            input int pal, input int wcode, input int hcode);
    mem[2*n]   = {6'd0, 10'(x), 1'(mode), 3'd0, 12'(addr)};
    mem[2*n+1] = {2'(hcode), 2'(wcode), 4'(pal), 4'(coll), 2'(z), 1'(vflip),
                  1'(hflip), 6'd0, 10'(y)};
  endtask

  // Reference: scan the table in order, collect covering sprites, stop at MAXL.
  task automatic build_model(input int line);
    logic [31:0] w0, w1;
    int   y, h, diff;
    pay_t p;
    exp_q.delete();
    exp_ovf = 1'b0;
    for (int n = 0; n < 128; n++) begin
      w0   = mem[2*n];
      w1   = mem[2*n+1];
      y    = int'(w1[9:0]);
      h    = 8 << w1[31:30];
      diff = (line - y + 1024) % 1024;
      if (w1[19:18] != 2'd0 && diff < h) begin
        p.idx   = 7'(n);
        p.addr  = w0[11:0];
        p.mode  = w0[15];
        p.x     = w0[25:16];
        p.row   = w1[17] ? 6'(h - 1 - diff) : 6'(diff);
        p.hflip = w1[16];
        p.z     = w1[19:18];
        p.coll  = w1[23:20];
        p.pal   = w1[27:24];
        p.wcode = w1[29:28];
        exp_q.push_back(p);
        if (exp_q.size() == MAXL) begin
          exp_ovf = (n < 127);
          break;
        end
      end
    end
  endtask

  // Pulse line_start for the given line, consume outputs with random
  // back-pressure and compare each transfer against the model until done_o.
  task automatic run_scan(input int line, input int ready_pct);
    int   cyc;
    bit   prev_stall;
    pay_t prev;
    pay_t e;
    build_model(line);
    n_xfer     = 0;
    done_cyc   = -1;
    prev_stall = 1'b0;
    @(negedge clk_i);
    line_start_i = 1'b1;
    line_idx_i   = 10'(line);
    out_ready_i  = 1'b0;
    @(negedge clk_i);
    line_start_i = 1'b0;
    checks++;
    if (out_valid_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL scan_start line=%0d: valid=%b busy=%b, want valid=0 busy=1",
               line, out_valid_o, busy_o);
    end
    cyc = 1;
    while (cyc < 3000) begin
      if (done_o === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      out_ready_i = ($urandom_range(99) < ready_pct);
      if (prev_stall) begin
        checks++;
        if (out_valid_o !== 1'b1 || dut_pay !== prev) begin
          errors++;
          $display("FAIL stall_stable line=%0d: valid=%b pay=%h, want valid=1 pay=%h",
                   line, out_valid_o, dut_pay, prev);
        end
      end
      if (out_valid_o === 1'b1) begin
        if (out_ready_i) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_output line=%0d: got pay=%h, want no output",
                     line, dut_pay);
          end else begin
            e = exp_q.pop_front();
            if (dut_pay !== e) begin
              errors++;
              $display("FAIL payload line=%0d: got %h, want %h", line, dut_pay, e);
            end
          end
          n_xfer++;
          last_xfer  = dut_pay;
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
          prev       = dut_pay;
        end
      end else begin
        prev_stall = 1'b0;
      end
      @(negedge clk_i);
      cyc++;
    end
    out_ready_i = 1'b0;
    checks++;
    if (done_cyc < 0) begin
      errors++;
      $display("FAIL done_timeout line=%0d: no done_o within 3000 cycles", line);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_outputs line=%0d: %0d expected sprites never sent",
               line, exp_q.size());
    end
`ifdef SPRITE_FETCH_OVERFLOW_EN
    checks++;
    if (overflow_o !== exp_ovf) begin
      errors++;
      $display("FAIL overflow line=%0d: got %b, want %b", line, overflow_o, exp_ovf);
    end
`endif
    @(negedge clk_i);
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse line=%0d: done=%b busy=%b one cycle later, want 0 0",
               line, done_o, busy_o);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (rd_en_o !== 1'b0 || rd_addr_o !== 8'd0 || out_valid_o !== 1'b0 ||
        busy_o !== 1'b0 || done_o !== 1'b0 || dut_pay !== '0) begin
      errors++;
      $display("FAIL %s: rd_en=%b addr=%h valid=%b busy=%b done=%b pay=%h, want all 0",
               tag, rd_en_o, rd_addr_o, out_valid_o, busy_o, done_o, dut_pay);
    end
`ifdef SPRITE_FETCH_OVERFLOW_EN
    checks++;
    if (overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_overflow: got %b, want 0", tag, overflow_o);
    end
`endif
  endtask

  task automatic check_stays_idle(input string tag);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      checks++;
      if (busy_o !== 1'b0 || rd_en_o !== 1'b0 || done_o !== 1'b0) begin
        errors++;
        $display("FAIL %s: busy=%b rd_en=%b done=%b after reset release, want 0",
                 tag, busy_o, rd_en_o, done_o);
      end
    end
  endtask

  task automatic test_reset();
    rst_n_i      = 1'b0;
    line_start_i = 1'b0;
    line_idx_i   = '0;
    out_ready_i  = 1'b0;
    clear_mem();
    repeat (3) @(negedge clk_i);
    check_reset_outputs("reset_state");
    rst_n_i = 1'b1;
    check_stays_idle("no_autostart");
  endtask

  task automatic test_sprite1();
    clear_mem();
    set_sprite(1, 'h100, 1, 60, 3, 0, 0, 1, 0, 0, 2, 1);
    run_scan(5, 100);
    checks++;
    if (n_xfer != 1 || last_xfer.idx !== 7'd1 || last_xfer.addr !== 12'h100 ||
        last_xfer.x !== 10'd60 || last_xfer.row !== 6'd2 ||
        last_xfer.wcode !== 2'd2 || last_xfer.mode !== 1'b1) begin
      errors++;
      $display("FAIL sprite1: n=%0d idx=%0d addr=%h x=%0d row=%0d wcode=%0d mode=%b, want 1 1 100 60 2 2 1",
               n_xfer, last_xfer.idx, last_xfer.addr, last_xfer.x, last_xfer.row,
               last_xfer.wcode, last_xfer.mode);
    end
  endtask

  task automatic test_vflip();
    clear_mem();
    set_sprite(1, 'h100, 1, 60, 3, 0, 1, 1, 0, 0, 2, 1);
    run_scan(5, 30);
    checks++;
    if (n_xfer != 1 || last_xfer.row !== 6'd13) begin
      errors++;
      $display("FAIL vflip_row: n=%0d row=%0d, want n=1 row=13", n_xfer, last_xfer.row);
    end
  endtask

  task automatic test_wrap();
    clear_mem();
    set_sprite(4, 'h3a5, 0, 900, 1020, 1, 0, 1, 5, 9, 1, 1);
    run_scan(4, 70);
    checks++;
    if (n_xfer != 1 || last_xfer.row !== 6'd8 || last_xfer.idx !== 7'd4) begin
      errors++;
      $display("FAIL wrap_hit: n=%0d idx=%0d row=%0d, want n=1 idx=4 row=8",
               n_xfer, last_xfer.idx, last_xfer.row);
    end
    run_scan(12, 100);
    checks++;
    if (n_xfer != 0) begin
      errors++;
      $display("FAIL wrap_miss: %0d outputs, want 0", n_xfer);
    end
  endtask

  task automatic test_all_miss();
    clear_mem();
    run_scan(37, 100);
    checks++;
    if (n_xfer != 0 || done_cyc != 385) begin
      errors++;
      $display("FAIL all_miss: outputs=%0d done_cycle=%0d, want 0 and 385",
               n_xfer, done_cyc);
    end
  endtask

  task automatic test_overflow();
    clear_mem();
    for (int n = 0; n < 70; n++)
      set_sprite(n, $urandom_range(4095), $urandom_range(1), $urandom_range(1023),
                 300, $urandom_range(1), $urandom_range(1), $urandom_range(1, 3),
                 $urandom_range(15), $urandom_range(15), $urandom_range(3),
                 $urandom_range(3));
    run_scan(302, 50);
    checks++;
    if (n_xfer != MAXL) begin
      errors++;
      $display("FAIL overflow_count: %0d transfers, want %0d", n_xfer, MAXL);
    end
  endtask

  task automatic test_restart();
    int k;
    clear_mem();
    set_sprite(0, 'h011, 0, 10, 100, 0, 0, 2, 1, 2, 0, 3);
    set_sprite(3, 'h033, 1, 30, 125, 1, 0, 3, 3, 4, 1, 0);
    @(negedge clk_i);
    out_ready_i  = 1'b0;
    line_start_i = 1'b1;
    line_idx_i   = 10'd100;
    @(negedge clk_i);
    line_start_i = 1'b0;
    k = 0;
    while (out_valid_o !== 1'b1 && k < 20) begin
      @(negedge clk_i);
      k++;
    end
    checks++;
    if (out_valid_o !== 1'b1 || idx_o !== 7'd0) begin
      errors++;
      $display("FAIL restart_first_hit: valid=%b idx=%0d, want 1 and 0",
               out_valid_o, idx_o);
    end
    repeat (3) @(negedge clk_i);
    checks++;
    if (out_valid_o !== 1'b1 || row_o !== 6'd0) begin
      errors++;
      $display("FAIL restart_hold: valid=%b row=%0d, want 1 and 0", out_valid_o, row_o);
    end
    // New line while stalled: sprite 0 must be rescanned (row 30), then sprite 3.
    run_scan(130, 60);
    checks++;
    if (n_xfer != 2) begin
      errors++;
      $display("FAIL restart_rescan: %0d transfers, want 2", n_xfer);
    end
  endtask

  task automatic test_random();
    int line;
    for (int it = 0; it < 6; it++) begin
      line = $urandom_range(1023);
      for (int i = 0; i < 256; i++) mem[i] = $urandom();
      for (int n = 0; n < 128; n++)
        if ($urandom_range(1))
          mem[2*n+1][9:0] = 10'((line - $urandom_range(80) + 1024) % 1024);
      run_scan(line, 20 + 15 * it);
    end
  endtask

  task automatic test_mid_reset();
    int k;
    clear_mem();
    set_sprite(2, 'hfff, 1, 1023, 50, 1, 1, 3, 15, 15, 3, 2);
    @(negedge clk_i);
    out_ready_i  = 1'b0;
    line_start_i = 1'b1;
    line_idx_i   = 10'd60;
    @(negedge clk_i);
    line_start_i = 1'b0;
    k = 0;
    while (out_valid_o !== 1'b1 && k < 30) begin
      @(negedge clk_i);
      k++;
    end
    checks++;
    if (out_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_setup: valid=%b, want 1", out_valid_o);
    end
    #2 rst_n_i = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk_i);
    rst_n_i = 1'b1;
    check_stays_idle("no_autostart_after_mid_reset");
  endtask

  initial begin
    test_reset();
    test_sprite1();
    test_vflip();
    test_wrap();
    test_all_miss();
    test_overflow();
    test_restart();
    test_random();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
